frame_deframer: RTL
===================

// Module: frame_deframer
// PURPOSE
//  Sits directly downstream of the BPSK signal demodulator and consumes its per-symbol
//  bit decisions (bit_in, qualified by the one-cycle bit_valid strobe).
//  Hunts for a sync word, reads a length byte, then assembles payload bits MSB-first into bytes.
//  Buffers the bytes in a small FIFO and presents them on a valid/ready byte interface.
// PARAMETERS
//  SYNC_WORD   16'hA5C3  16-bit frame sync pattern, MSB received first
//  FIFO_DEPTH  8         output FIFO entries; power of two, >= 2
// PORTS
//  clock        in   1   system clock, rising edge
//  reset_n      in   1   asynchronous active-low reset
//  bit_in       in   1   demodulated bit decision
//  bit_valid    in   1   one-cycle strobe: bit_in valid this cycle
//  out_data     out  8   FIFO head byte
//  out_valid    out  1   FIFO not empty
//  out_ready    in   1   consumer accepts out_data this cycle
//  sync_locked  out  1   high while inside a frame (LEN/PAYLOAD/CRC states)
//  frame_done   out  1   one-cycle pulse when a frame ends normally
//  overflow     out  1   one-cycle pulse when a payload byte is dropped (FIFO full)
//  frame_error  out  1   one-cycle pulse on CRC mismatch (tied 0 without FRAME_CRC_EN)
// BEHAVIOUR
//  - Reset (async assert, sync release): state=HUNT, shift reg=0, bit count=0, FIFO empty.
//    All outputs 0; out_data=8'h00.
//  - Only cycles with bit_valid=1 advance the datapath; bit_in is ignored otherwise.
//  - HUNT: shift bit_in into the LSB of a 16-bit register.
//    When the updated register equals SYNC_WORD -> LEN, bit count=0.
//  - LEN: collect 8 bits MSB-first into len.
//    On the 8th bit: len==0 -> pulse frame_done, go to HUNT; else -> PAYLOAD, byte count=0.
//  - PAYLOAD: collect 8 bits into a byte; on the 8th bit push to FIFO, byte count+1.
//    After byte len: go to CRC if FRAME_CRC_EN, else pulse frame_done and go to HUNT.
//  - Every return to HUNT clears the shift reg, so a new sync needs 16 fresh bits.
//    Sync bits overlapping the previous frame never match.
//  - Latency: byte visible on out_data/out_valid the cycle after the bit_valid cycle
//    that carried its 8th bit (FIFO was empty).
//  - Handshake: pop when out_valid && out_ready. out_data stays stable while out_valid && !out_ready.
//  - FIFO full on push: byte dropped, overflow pulses, frame continues and byte count still advances.
//    Exception: a pop in the same cycle frees a slot, the push succeeds and there is no overflow.
//  - Push on an empty FIFO with out_ready=1: the byte still appears the next cycle (no fall-through).
//  - FIFO pointers are log2(FIFO_DEPTH)+1 bits; full/empty are derived from the MSB compare.
//    Wrap-around is seamless.
//  - Reset mid-frame: frame is abandoned and the FIFO is flushed (buffered bytes are lost).
//  - Each bit_valid consumes exactly one bit. Back-to-back bit_valid strobes on consecutive
//    cycles are supported.
// CONFIGURATION
//  - FRAME_CRC_EN defined: CRC state collects one trailing byte.
//    CRC-8 (poly 0x07, init 0x00, non-reflected) is computed over len plus payload bytes,
//    including dropped bytes.
//    Match -> frame_done pulse; mismatch -> frame_error pulse (no frame_done).
//    Either way return to HUNT. Bytes already pushed are not retracted.
//  - FRAME_CRC_EN undefined: no CRC state or logic; frame_error is constant 0.
// TESTING
//  - Stream A5 C3 02 11 22, out_ready=1 -> out_data 0x11 then 0x22; frame_done 1 pulse;
//    sync_locked high from the sync match to frame end.
//  - Idle bits then A5 C3 00 -> frame_done pulse, no FIFO writes, state back in HUNT.
//  - out_ready=0, sync+len=0x0A+10 bytes, FIFO_DEPTH=8 -> 8 bytes held, 2 overflow pulses.
//    Then out_ready=1 drains exactly the first 8 bytes in order.
//  - Reset asserted after 5 payload bits of the frame in the first case
//    -> all outputs 0 immediately, FIFO empty. A new frame is received correctly.
//  - FRAME_CRC_EN: A5 C3 02 11 22 7A -> frame_done. Same frame with CRC 7B -> frame_error,
//    yet 0x11 and 0x22 are still output.
//  - bit_valid gaps of 0..20 cycles between bits -> output identical to back-to-back strobes.

Source files
------------

// File: rtl/frame_deframer.sv
// Bit-serial frame deframer: sync hunt, length byte, MSB-first payload assembly into an output FIFO.
// Optional trailing CRC-8 check is enabled by defining FRAME_CRC_EN.
module frame_deframer #(
  parameter logic [15:0] SYNC_WORD  = 16'hA5C3,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       sync_locked,
  output logic       frame_done,
  output logic       overflow,
  output logic       frame_error
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

`ifdef FRAME_CRC_EN
  typedef enum logic [1:0] {StHunt, StLen, StPayload, StCrc} state_e;
`else
  typedef enum logic [1:0] {StHunt, StLen, StPayload} state_e;
`endif

  state_e      state_q, state_d;
  // Only the last 15 bits are kept; the 16th comes straight from bit_in.
  logic [14:0] shift_q, shift_d;
  logic [15:0] sync_cand;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  data_q, data_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  byte_full;
  logic        done_d, done_q;
  logic        ovf_d, ovf_q;
  logic        push_req, push, pop, full, empty;
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic [7:0]  mem_q [FIFO_DEPTH];

`ifdef FRAME_CRC_EN
  logic [7:0] crc_q, crc_d;
  logic       err_d, err_q;

  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
    return {c[6:0], 1'b0} ^ ((c[7] ^ b) ? 8'h07 : 8'h00);
  endfunction
`endif

  assign sync_cand = {shift_q, bit_in};
  assign byte_full = {data_q, bit_in};

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    data_d     = data_q;
    len_d      = len_q;
    byte_cnt_d = byte_cnt_q;
    done_d     = 1'b0;
    push_req   = 1'b0;
`ifdef FRAME_CRC_EN
    crc_d      = crc_q;
    err_d      = 1'b0;
`endif
    if (bit_valid) begin
      case (state_q)
        StHunt: begin
          shift_d = sync_cand[14:0];
          if (sync_cand == SYNC_WORD) begin
            state_d   = StLen;
            bit_cnt_d = 3'd0;
`ifdef FRAME_CRC_EN
            crc_d     = 8'h00;
`endif
          end
        end
        StLen: begin
          data_d    = byte_full[6:0];
          bit_cnt_d = bit_cnt_q + 3'd1;
`ifdef FRAME_CRC_EN
          crc_d     = crc_step(crc_q, bit_in);
`endif
          if (bit_cnt_q == 3'd7) begin
            len_d = byte_full;
            if (byte_full == 8'h00) begin
              done_d  = 1'b1;
              state_d = StHunt;
              shift_d = '0;
            end else begin
              state_d    = StPayload;
              byte_cnt_d = 8'h00;
            end
          end
        end
        StPayload: begin
          data_d    = byte_full[6:0];
          bit_cnt_d = bit_cnt_q + 3'd1;
`ifdef FRAME_CRC_EN
          crc_d     = crc_step(crc_q, bit_in);
`endif
          if (bit_cnt_q == 3'd7) begin
            push_req   = 1'b1;
            byte_cnt_d = byte_cnt_q + 8'd1;
            if (byte_cnt_q + 8'd1 == len_q) begin
`ifdef FRAME_CRC_EN
              state_d = StCrc;
`else
              done_d  = 1'b1;
              state_d = StHunt;
              shift_d = '0;
`endif
            end
          end
        end
`ifdef FRAME_CRC_EN
        StCrc: begin
          data_d    = byte_full[6:0];
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (byte_full == crc_q) done_d = 1'b1;
            else                    err_d  = 1'b1;
            state_d = StHunt;
            shift_d = '0;
          end
        end
`endif
        default: state_d = StHunt;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StHunt;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      data_q     <= '0;
      len_q      <= '0;
      byte_cnt_q <= '0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      data_q     <= data_d;
      len_q      <= len_d;
      byte_cnt_q <= byte_cnt_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
    end
  end

`ifdef FRAME_CRC_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      crc_q <= 8'h00;
      err_q <= 1'b0;
    end else begin
      crc_q <= crc_d;
      err_q <= err_d;
    end
  end
  assign frame_error = err_q;
`else
  assign frame_error = 1'b0;
`endif

  // FIFO: pointer MSB distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = !empty && out_ready;
  // A same-cycle pop frees the slot the push lands in.
  assign push  = push_req && (!full || pop);
  assign ovf_d = push_req && full && !pop;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= byte_full;
  end

  assign out_valid   = !empty;
  assign out_data    = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
  assign sync_locked = (state_q != StHunt);
  assign frame_done  = done_q;
  assign overflow    = ovf_q;

endmodule
